// File: rtl/ryu_controller.sv
// Per-frame movement and pose controller for Ryu: walk, jump physics, punch timer, death.
// All state advances only on frame_tick; outputs come straight from registers.
module ryu_controller #(
    parameter int unsigned X_INIT       = 100,
    parameter int unsigned X_MIN        = 0,
    parameter int unsigned X_MAX        = 576,
    parameter int unsigned GROUND_Y     = 300,
    parameter int unsigned X_STEP       = 3,
    parameter int unsigned JUMP_V0      = 12,
    parameter int unsigned GRAVITY      = 1,
    parameter int unsigned PUNCH_FRAMES = 12
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_punch,
    input  logic        dead,
    output logic [9:0]  RyuX,
    output logic [9:0]  RyuY,
    output logic [2:0]  sprite,
    output logic        attacking
);

    localparam int unsigned POS_W = 10;
    localparam int unsigned VY_W  = 7;
    localparam int unsigned SUM_W = 12;
    localparam int unsigned CNT_W = (PUNCH_FRAMES > 2) ? $clog2(PUNCH_FRAMES) : 1;

    localparam logic [POS_W-1:0]        X_INIT_P = POS_W'(X_INIT);
    localparam logic [POS_W-1:0]        X_MIN_P  = POS_W'(X_MIN);
    localparam logic [POS_W-1:0]        X_MAX_P  = POS_W'(X_MAX);
    localparam logic [POS_W-1:0]        X_STEP_P = POS_W'(X_STEP);
    localparam logic [POS_W-1:0]        X_LO_LIM = POS_W'(X_MIN + X_STEP);
    localparam logic [POS_W-1:0]        X_HI_LIM = POS_W'(X_MAX - X_STEP);
    localparam logic [POS_W-1:0]        GROUND_P = POS_W'(GROUND_Y);
    localparam logic signed [SUM_W-1:0] GROUND_S = SUM_W'(GROUND_Y);
    localparam logic signed [VY_W-1:0]  VY0      = VY_W'(JUMP_V0);
    localparam logic signed [VY_W-1:0]  GRAV     = VY_W'(GRAVITY);
    localparam logic [CNT_W-1:0]        CNT_LOAD = CNT_W'(PUNCH_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_STAND    = 3'd0,
        ST_PUNCH    = 3'd1,
        ST_JUMP     = 3'd2,
        ST_CROUCH   = 3'd3,
        ST_WALK_L   = 3'd4,
        ST_WALK_R   = 3'd5,
        ST_DEATH    = 3'd6,
        ST_JUMP_ATK = 3'd7
    } state_e;

    state_e                  state_q, state_d;
    logic [POS_W-1:0]        x_q, x_d;
    logic [POS_W-1:0]        y_q, y_d;
    logic signed [VY_W-1:0]  vy_q, vy_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [1:0]       jdir_q, jdir_d;
    logic                    attacking_q, attacking_d;
    logic signed [1:0]       key_dir_c;
    logic signed [SUM_W-1:0] y_sum_c;

    // Saturating horizontal step: dir -1 left, +1 right, 0 hold.
    function automatic logic [POS_W-1:0] step_x(input logic [POS_W-1:0] x,
                                                 input logic signed [1:0] dir);
        logic [POS_W-1:0] r;
        r = x;
        if (dir == 2'sb11) begin
            r = (x < X_LO_LIM) ? X_MIN_P : x - X_STEP_P;
        end else if (dir == 2'sb01) begin
            r = (x > X_HI_LIM) ? X_MAX_P : x + X_STEP_P;
        end
        return r;
    endfunction

    always_comb begin
        key_dir_c = 2'sb00;
        if (key_left && !key_right) begin
            key_dir_c = 2'sb11;
        end else if (key_right && !key_left) begin
            key_dir_c = 2'sb01;
        end
    end

    assign y_sum_c = $signed({2'b00, y_q}) + {{(SUM_W-VY_W){vy_q[VY_W-1]}}, vy_q};

    // Next-state, position and physics update, gated by frame_tick.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vy_d    = vy_q;
        cnt_d   = cnt_q;
        jdir_d  = jdir_q;
        if (frame_tick) begin
            if (dead) begin
                state_d = ST_DEATH;
                y_d     = GROUND_P;
            end else begin
                case (state_q)
                    ST_STAND, ST_WALK_L, ST_WALK_R, ST_CROUCH: begin
                        if (key_punch) begin
                            state_d = ST_PUNCH;
                            cnt_d   = CNT_LOAD;
                        end else if (key_up) begin
                            state_d = ST_JUMP;
                            vy_d    = -VY0;
                            jdir_d  = key_dir_c;
                        end else if (key_down) begin
                            state_d = ST_CROUCH;
                        end else if (key_dir_c == 2'sb11) begin
                            state_d = ST_WALK_L;
                            x_d     = step_x(x_q, key_dir_c);
                        end else if (key_dir_c == 2'sb01) begin
                            state_d = ST_WALK_R;
                            x_d     = step_x(x_q, key_dir_c);
                        end else begin
                            state_d = ST_STAND;
                        end
                    end
                    ST_JUMP, ST_JUMP_ATK: begin
                        if (y_sum_c >= GROUND_S) begin
                            state_d = ST_STAND;
                            y_d     = GROUND_P;
                        end else begin
                            y_d  = y_sum_c[POS_W-1:0];
                            vy_d = vy_q + GRAV;
                            x_d  = step_x(x_q, jdir_q);
                            if (key_punch) begin
                                state_d = ST_JUMP_ATK;
                            end
                        end
                    end
                    ST_PUNCH: begin
                        if (cnt_q == '0) begin
                            state_d = ST_STAND;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    ST_DEATH: begin
                        state_d = ST_DEATH;
                    end
                    default: begin
                        state_d = ST_STAND;
                    end
                endcase
            end
        end
        attacking_d = (state_d == ST_PUNCH) || (state_d == ST_JUMP_ATK);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_STAND;
            x_q         <= X_INIT_P;
            y_q         <= GROUND_P;
            vy_q        <= '0;
            cnt_q       <= '0;
            jdir_q      <= 2'sb00;
            attacking_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vy_q        <= vy_d;
            cnt_q       <= cnt_d;
            jdir_q      <= jdir_d;
            attacking_q <= attacking_d;
        end
    end

    assign RyuX      = x_q;
    assign RyuY      = y_q;
    assign sprite    = state_q;
    assign attacking = attacking_q;

endmodule

// File: tb/tb_ryu_controller.sv
// Directed bench for ryu_controller: walk clamp, jump arc, jump attack, punch timer, death and reset.
module tb_ryu_controller;

    logic       vga_clk;
    logic       reset_n;
    logic       frame_tick;
    logic       key_left, key_right, key_up, key_down, key_punch, dead;
    logic [9:0] RyuX, RyuY;
    logic [2:0] sprite;
    logic       attacking;

    int n_checks;
    int n_errors;

    ryu_controller dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_punch  (key_punch),
        .dead       (dead),
        .RyuX       (RyuX),
        .RyuY       (RyuY),
        .sprite     (sprite),
        .attacking  (attacking)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame: tick pulse for a single cycle, then two idle cycles; returns at a negedge.
    task automatic do_tick();
        @(negedge vga_clk);
        frame_tick = 1'b1;
        @(negedge vga_clk);
        frame_tick = 1'b0;
        repeat (2) @(negedge vga_clk);
    endtask

    task automatic check_pose(input string tag, input int spr, input int x, input int y, input int atk);
        check({tag, ".sprite"}, int'(sprite), spr);
        check({tag, ".x"}, int'(RyuX), x);
        check({tag, ".y"}, int'(RyuY), y);
        check({tag, ".atk"}, int'(attacking), atk);
    endtask

    initial begin
        int ex;
        int min_y;
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        key_left   = 1'b0;
        key_right  = 1'b0;
        key_up     = 1'b0;
        key_down   = 1'b0;
        key_punch  = 1'b0;
        dead       = 1'b0;
        repeat (3) @(negedge vga_clk);
        check_pose("reset", 0, 100, 300, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            do_tick();
            check_pose("idle", 0, 100, 300, 0);
        end

        // Walk left into the left clamp.
        key_left = 1'b1;
        ex = 100;
        for (int i = 1; i <= 40; i++) begin
            do_tick();
            ex = (ex < 3) ? 0 : ex - 3;
            check("walk_l.sprite", int'(sprite), 4);
            check("walk_l.x", int'(RyuX), ex);
            if (i == 33) check("walk_l.x33", int'(RyuX), 1);
            if (i == 34) check("walk_l.x34", int'(RyuX), 0);
        end
        key_left = 1'b0;
        do_tick();
        check_pose("walk_stop", 0, 0, 300, 0);

        // Vertical jump from X=0.
        key_up = 1'b1;
        do_tick();
        key_up = 1'b0;
        check_pose("takeoff", 2, 0, 300, 0);
        min_y = 1000;
        for (int i = 1; i <= 25; i++) begin
            do_tick();
            if (int'(RyuY) < min_y) min_y = int'(RyuY);
            if (i < 25) check("jump.sprite", int'(sprite), 2);
            if (i == 12) check("jump.y12", int'(RyuY), 222);
            if (i == 13) check("jump.apex", int'(RyuY), 222);
            if (i == 24) check("jump.y24", int'(RyuY), 288);
            check("jump.x", int'(RyuX), 0);
        end
        check_pose("land", 0, 0, 300, 0);
        check("jump.min_y", min_y, 222);

        // Jump right with a mid-air punch.
        key_up    = 1'b1;
        key_right = 1'b1;
        do_tick();
        key_up    = 1'b0;
        key_right = 1'b0;
        check_pose("jr_takeoff", 2, 0, 300, 0);
        for (int i = 1; i <= 25; i++) begin
            key_punch = (i == 5);
            do_tick();
            key_punch = 1'b0;
            if (i < 5) begin
                check("jr.sprite", int'(sprite), 2);
                check("jr.atk", int'(attacking), 0);
            end else if (i < 25) begin
                check("jr.sprite_atk", int'(sprite), 7);
                check("jr.atk", int'(attacking), 1);
            end
            if (i < 25) check("jr.x", int'(RyuX), 3 * i);
        end
        check_pose("jr_land", 0, 72, 300, 0);

        // Punch: 12 ticks, jump request ignored, X frozen.
        key_punch = 1'b1;
        do_tick();
        key_punch = 1'b0;
        check_pose("punch1", 1, 72, 300, 1);
        for (int i = 2; i <= 12; i++) begin
            key_up = (i == 5);
            do_tick();
            key_up = 1'b0;
            check_pose("punch", 1, 72, 300, 1);
        end
        do_tick();
        check_pose("punch_end", 0, 72, 300, 0);

        // Keys between ticks must not move anything.
        key_right = 1'b1;
        repeat (6) @(negedge vga_clk);
        check_pose("no_tick", 0, 72, 300, 0);
        key_right = 1'b0;
        do_tick();
        check_pose("no_tick_after", 0, 72, 300, 0);

        // Death mid-jump, sticky, then async reset.
        key_up = 1'b1;
        do_tick();
        key_up = 1'b0;
        repeat (3) do_tick();
        check_pose("pre_death", 2, 72, 267, 0);
        dead = 1'b1;
        do_tick();
        dead = 1'b0;
        check_pose("death", 6, 72, 300, 0);
        key_left = 1'b1;
        key_up   = 1'b1;
        repeat (2) do_tick();
        key_left = 1'b0;
        key_up   = 1'b0;
        check_pose("death_sticky", 6, 72, 300, 0);
        reset_n = 1'b0;
        #1;
        check_pose("async_reset", 0, 100, 300, 0);
        @(negedge vga_clk);
        reset_n = 1'b1;
        do_tick();
        check_pose("post_reset", 0, 100, 300, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
